// File: rtl/mux_pkg.sv
// Shared definitions for the parameterised stream multiplexer: mode encodings and
// the select-index width helper used by both the top level and the arbiter.
package mux_pkg;

  localparam int unsigned MODE_SEL = 0;
  localparam int unsigned MODE_RR  = 1;

  // Select/index width: clog2(n), but never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr (wrapping) and
// moves ptr past the granted channel only when the caller reports a transfer.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int unsigned N  = 8,
  localparam int unsigned SW = sel_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] grant_idx
);

  logic [SW-1:0] r_ptr;
  logic          w_found;

  always_comb begin : search
    int unsigned idx;
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(r_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!w_found && req[idx]) begin
        w_found        = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = SW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (advance) begin
      r_ptr <= (grant_idx == SW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/param_stream_mux.sv
// N-to-1 valid/ready stream multiplexer with a registered output stage; channel
// choice is either an external select or round-robin arbitration.
module param_stream_mux
  import mux_pkg::*;
#(
  parameter  int unsigned N    = 8,
  parameter  int unsigned W    = 8,
  parameter  int unsigned MODE = MODE_RR,
  localparam int unsigned SW   = sel_width(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [SW-1:0]  out_ch
);

  logic          w_load_en;
  logic          w_in_xfer;
  logic          w_advance;
  logic [N-1:0]  w_sel_grant;
  logic [N-1:0]  w_rr_grant;
  logic [N-1:0]  w_grant;
  logic [SW-1:0] w_rr_idx;
  logic [SW-1:0] w_grant_idx;
  logic [W-1:0]  w_mux_data;

  logic [W-1:0]  r_out_data;
  logic          r_out_valid;
  logic [SW-1:0] r_out_ch;

  // An out-of-range select matches no channel, so nothing is granted.
  always_comb begin
    w_sel_grant = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (sel == SW'(i)) w_sel_grant[i] = 1'b1;
    end
  end

  rr_arbiter #(
    .N(N)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (in_valid),
    .advance  (w_advance),
    .grant    (w_rr_grant),
    .grant_idx(w_rr_idx)
  );

  assign w_grant     = (MODE == MODE_RR) ? w_rr_grant : w_sel_grant;
  assign w_grant_idx = (MODE == MODE_RR) ? w_rr_idx : sel;

  // Grant never looks at ready; ready only gates the grant.
  assign w_load_en = !r_out_valid || out_ready;
  assign in_ready  = (rst || !w_load_en) ? '0 : w_grant;
  assign w_in_xfer = |(in_ready & in_valid);
  assign w_advance = w_in_xfer && (MODE == MODE_RR);

  always_comb begin
    w_mux_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (w_grant[i]) w_mux_data = in_data[i*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
    end else if (w_load_en) begin
      r_out_valid <= w_in_xfer;
      if (w_in_xfer) begin
        r_out_data <= w_mux_data;
        r_out_ch   <= w_grant_idx;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_param_stream_mux.sv
// Bench for param_stream_mux: round-robin instance against a queue-based reference
// with a decoupled output monitor, plus directed checks on two select-mode instances.
module tb_param_stream_mux;
  import mux_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Round-robin instance, N=8 W=8
  logic        rst_r = 1'b1;
  logic [63:0] data_r = '0;
  logic [7:0]  inv_r = '0;
  logic [7:0]  in_ready_r;
  logic [2:0]  sel_r = '0;
  logic [7:0]  out_data_r;
  logic        out_valid_r;
  logic        ordy_r = 1'b0;
  logic [2:0]  out_ch_r;

  // Select-mode instances: N=8 and N=5
  logic        rst_s = 1'b1;
  logic [63:0] data_a = '0;
  logic [7:0]  inv_a = '0;
  logic [7:0]  in_ready_a;
  logic [2:0]  sel_a = '0;
  logic [7:0]  out_data_a;
  logic        out_valid_a;
  logic        ordy_a = 1'b1;
  logic [2:0]  out_ch_a;

  logic [39:0] data_b = '0;
  logic [4:0]  inv_b = '0;
  logic [4:0]  in_ready_b;
  logic [2:0]  sel_b = '0;
  logic [7:0]  out_data_b;
  logic        out_valid_b;
  logic        ordy_b = 1'b1;
  logic [2:0]  out_ch_b;

  param_stream_mux #(.N(8), .W(8), .MODE(MODE_RR)) u_rr (
    .clk(clk), .rst(rst_r), .in_data(data_r), .in_valid(inv_r), .in_ready(in_ready_r),
    .sel(sel_r), .out_data(out_data_r), .out_valid(out_valid_r), .out_ready(ordy_r),
    .out_ch(out_ch_r)
  );

  param_stream_mux #(.N(8), .W(8), .MODE(MODE_SEL)) u_sel (
    .clk(clk), .rst(rst_s), .in_data(data_a), .in_valid(inv_a), .in_ready(in_ready_a),
    .sel(sel_a), .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(ordy_a),
    .out_ch(out_ch_a)
  );

  param_stream_mux #(.N(5), .W(8), .MODE(MODE_SEL)) u_sel5 (
    .clk(clk), .rst(rst_s), .in_data(data_b), .in_valid(inv_b), .in_ready(in_ready_b),
    .sel(sel_b), .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(ordy_b),
    .out_ch(out_ch_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a pending-beat flag, a search pointer and a queue of {ch, data}.
  logic        m_valid = 1'b0;
  int          m_ptr = 0;
  logic        m_was_rst = 1'b0;
  logic [10:0] q[$];

  function automatic int rr_pick(input logic [7:0] v, input int p);
    for (int k = 0; k < 8; k++) begin
      if (v[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic rr_cycle(input logic r, input logic [7:0] v, input logic [63:0] d,
                          input logic ordy);
    int         g;
    logic       load;
    logic [7:0] exp_rdy;
    @(negedge clk);
    rst_r  = r;
    inv_r  = v;
    data_r = d;
    ordy_r = ordy;
    #1;
    check("out_valid", out_valid_r, m_valid);
    if (m_was_rst) begin
      check("rst_out_data", out_data_r, 8'h00);
      check("rst_out_ch", out_ch_r, 3'd0);
    end
    load    = !m_valid || ordy;
    g       = rr_pick(v, m_ptr);
    exp_rdy = '0;
    if (!r && load && g >= 0) exp_rdy[g] = 1'b1;
    check("in_ready", in_ready_r, exp_rdy);
    if (r) begin
      m_valid = 1'b0;
      m_ptr   = 0;
      q.delete();
    end else if (load) begin
      if (g >= 0) begin
        q.push_back({3'(g), d[g*8 +: 8]});
        m_valid = 1'b1;
        m_ptr   = (g + 1) % 8;
      end else begin
        m_valid = 1'b0;
      end
    end
    m_was_rst = r;
  endtask

  // Monitor: pops an expected beat whenever the round-robin output transfers, and
  // checks that a stalled beat stays put.
  initial begin : monitor
    logic        hold;
    logic [7:0]  hd;
    logic [2:0]  hc;
    logic [10:0] e;
    hold = 1'b0;
    hd   = '0;
    hc   = '0;
    forever begin
      @(negedge clk);
      #3;
      if (rst_r) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("stall_valid", out_valid_r, 1'b1);
          check("stall_data", out_data_r, hd);
          check("stall_ch", out_ch_r, hc);
        end
        if (out_valid_r === 1'b1 && ordy_r) begin
          if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_beat: got ch %0d data %0h, expected no beat",
                     out_ch_r, out_data_r);
          end else begin
            e = q.pop_front();
            check("beat_data", out_data_r, e[7:0]);
            check("beat_ch", out_ch_r, e[10:8]);
          end
        end
        hold = (out_valid_r === 1'b1) && !ordy_r;
        hd   = out_data_r;
        hc   = out_ch_r;
      end
    end
  end

  initial begin : stim
    logic [63:0] d;
    // Select-mode instances: reset state with every channel valid
    @(negedge clk);
    sel_a = 3'd5;
    inv_a = 8'hFF;
    sel_b = 3'd6;
    inv_b = 5'h1F;
    #1;
    check("sel_rst_in_ready", in_ready_a, 8'h00);
    check("sel_rst_valid", out_valid_a, 1'b0);
    check("sel_rst_data", out_data_a, 8'h00);
    check("sel_rst_ch", out_ch_a, 3'd0);

    @(negedge clk);
    rst_s  = 1'b0;
    data_a = {$urandom, $urandom};
    data_a[5*8 +: 8] = 8'hA5;
    data_b = {$urandom, $urandom};
    #1;
    check("sel5_in_ready", in_ready_a, 8'b0010_0000);
    check("sel_oob_in_ready", in_ready_b, 5'h00);

    @(negedge clk);
    inv_a = 8'hDF;
    sel_b = 3'd4;
    data_b[4*8 +: 8] = 8'h5A;
    #1;
    check("sel5_valid", out_valid_a, 1'b1);
    check("sel5_data", out_data_a, 8'hA5);
    check("sel5_ch", out_ch_a, 3'd5);
    check("sel_oob_valid", out_valid_b, 1'b0);
    check("sel5_idle_in_ready", in_ready_a, 8'b0010_0000);
    check("sel4_in_ready", in_ready_b, 5'b1_0000);

    @(negedge clk);
    #1;
    check("sel_idle_valid", out_valid_a, 1'b0);
    check("sel_idle_data_hold", out_data_a, 8'hA5);
    check("sel_idle_ch_hold", out_ch_a, 3'd5);
    check("sel4_valid", out_valid_b, 1'b1);
    check("sel4_data", out_data_b, 8'h5A);
    check("sel4_ch", out_ch_b, 3'd4);

    // Round-robin: reset with all channels requesting
    rr_cycle(1'b1, 8'hFF, {$urandom, $urandom}, 1'b1);
    // Full load, full drain: channels in order 0..7, 0
    for (int i = 0; i < 9; i++) rr_cycle(1'b0, 8'hFF, {$urandom, $urandom}, 1'b1);
    // Park the pointer at 3, then alternate between channels 7 and 2
    rr_cycle(1'b0, 8'h04, {$urandom, $urandom}, 1'b1);
    for (int i = 0; i < 3; i++) rr_cycle(1'b0, 8'h84, {$urandom, $urandom}, 1'b1);
    // Four-cycle downstream stall, then resume
    rr_cycle(1'b0, 8'hFF, {$urandom, $urandom}, 1'b1);
    for (int i = 0; i < 4; i++) rr_cycle(1'b0, 8'hFF, {$urandom, $urandom}, 1'b0);
    for (int i = 0; i < 4; i++) rr_cycle(1'b0, 8'hFF, {$urandom, $urandom}, 1'b1);
    // Reset while a stalled 3C beat is held
    rr_cycle(1'b0, 8'hFF, {8{8'h3C}}, 1'b1);
    rr_cycle(1'b0, 8'h00, {$urandom, $urandom}, 1'b0);
    rr_cycle(1'b1, 8'hFF, {$urandom, $urandom}, 1'b0);
    check("pre_rst_data", out_data_r, 8'h3C);
    rr_cycle(1'b0, 8'hFF, {$urandom, $urandom}, 1'b1);
    rr_cycle(1'b0, 8'h00, {$urandom, $urandom}, 1'b1);
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      d = {$urandom, $urandom};
      rr_cycle(1'b0, ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'($urandom & $urandom),
               d, $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 4; i++) rr_cycle(1'b0, 8'h00, {$urandom, $urandom}, 1'b1);
    @(negedge clk);
    #4;
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/param_stream_mux.md
PARAM_STREAM_MUX -- requirements
Module: param_stream_mux

Interface
REQ-001 SHALL have parameter N, default 8, number of input channels (2..32).
REQ-002 SHALL have parameter W, default 8, data width per channel (1..64).
REQ-003 SHALL have parameter MODE, default 1: 0 = external select, 1 = round-robin arbitration.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_data  input  N*W  channel i occupies bits [i*W +: W].
REQ-007 SHALL have port in_valid  input  N  per-channel valid.
REQ-008 SHALL have port in_ready  output  N  per-channel ready, combinational.
REQ-009 SHALL have port sel  input  SW=max(1,clog2(N))  channel select, used only in MODE 0.
REQ-010 SHALL have port out_data  output  W  registered output beat.
REQ-011 SHALL have port out_valid  output  1  registered output valid.
REQ-012 SHALL have port out_ready  input  1  downstream ready.
REQ-013 SHALL have port out_ch  output  SW  registered index of the channel that sourced out_data.

Function
REQ-014 SHALL transfer on an input when in_valid[i] and in_ready[i] are both 1 on a rising edge; on the output when out_valid and out_ready are both 1.
REQ-015 SHALL define load_en = !out_valid | out_ready; output register loads only when load_en = 1.
REQ-016 SHALL assert at most one in_ready bit per cycle: in_ready[i] = load_en & grant[i].
REQ-017 MODE 0: grant[i] = 1 iff i == sel and sel < N; sel >= N grants nothing, in_ready = 0.
REQ-018 MODE 1: grant = first channel with in_valid = 1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap-around).
REQ-019 MODE 1: ptr SHALL update to (granted index + 1) mod N only on an input transfer; otherwise hold.
REQ-020 grant SHALL NOT depend on in_ready or out_ready (no combinational loop through ready).
REQ-021 On an input transfer, next cycle out_data = in_data of granted channel, out_ch = its index, out_valid = 1; latency 1 cycle.
REQ-022 On output transfer with no input transfer, out_valid SHALL go 0 next cycle; out_data and out_ch hold.
REQ-023 Simultaneous output and input transfer SHALL sustain 1 beat/cycle with no bubble.
REQ-024 out_valid = 1 and out_ready = 0 SHALL hold out_data, out_ch, out_valid stable and force in_ready = 0.
REQ-025 No in_valid set (or MODE 0 with in_valid[sel] = 0) SHALL produce no transfer and leave ptr unchanged.

Reset
REQ-026 While rst = 1 on a rising edge: out_valid = 0, out_data = 0, out_ch = 0, ptr = 0.
REQ-027 rst = 1 SHALL force in_ready = 0 combinationally; a beat held mid-transfer is discarded.
REQ-028 First grant after reset in MODE 1 SHALL search from channel 0.

Structure
REQ-029 MODE encodings (MODE_SEL = 0, MODE_RR = 1) SHALL live in shared package mux_pkg.
REQ-030 Round-robin grant plus ptr SHALL be sub-module rr_arbiter (params N; ports clk, rst, req, advance, grant, grant_idx).
REQ-031 Top level SHALL contain only grant select, data mux, output register.

Verification
REQ-032 MODE 1, N=8, all in_valid = 1, out_ready = 1 -> out_ch sequence 0,1,...,7,0 one per cycle, out_valid stays 1.
REQ-033 MODE 1, in_valid = 8'b1000_0100, ptr = 3 -> grant channel 7, then channel 2 (wrap), then 7.
REQ-034 MODE 0, sel = 5, in_data ch5 = 8'hA5 -> out_data = 8'hA5, out_ch = 5 one cycle later; in_ready = 8'b0010_0000.
REQ-035 out_ready = 0 for 4 cycles with out_valid = 1 -> out_data stable, in_ready = 0, ptr unchanged; resume loses no beat.
REQ-036 N=5, MODE 0, sel = 6 -> in_ready = 0, out_valid stays 0.
REQ-037 rst asserted while out_valid = 1, out_data = 8'h3C -> next cycle out_valid = 0, out_data = 0, out_ch = 0; first grant afterwards ch0.
